// File: rtl/rand_range.sv
// rand_range: turns a free-running 8-bit random byte stream into a uniformly
// distributed value in [0, limit-1] on request. Uses mask-and-reject sampling:
// the byte is masked down to the smallest all-ones pattern covering limit-1,
// and out-of-range candidates are retried. After MAX_TRIES rejections a
// deterministic fallback (cand - limit) is delivered instead.
//
// Optional build macro: RAND_RANGE_NO_REPEAT_EN
//   When defined, the last delivered value is remembered. A candidate equal
//   to it is rejected (for limits of 2 or more), and a fallback equal to it is
//   bumped to the next value modulo limit. The result is that two consecutive
//   results never repeat.
//
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - synchronous, active-high reset
//   rnd_in - random byte from the generator, a new value every clock
//   req    - request pulse, only sampled while idle
//   limit  - exclusive upper bound, sampled with req (0 means 256)
//   value  - drawn value, valid only while valid=1, held until next result
//   valid  - one-cycle pulse, result available
//   busy   - high while a draw is in progress
module rand_range #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rnd_in,
  input  logic       req,
  input  logic [7:0] limit,
  output logic [7:0] value,
  output logic       valid,
  output logic       busy
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t        state, state_next;
  logic [7:0]    lim, lim_next;
  logic [7:0]    mask, mask_next;
  logic [TW-1:0] tries, tries_next;
  logic [7:0]    value_next;
  logic          valid_next;

  logic [8:0]    lim_ext;
  logic [7:0]    cand;
  logic [TW-1:0] tries_inc;
  logic          reject;
  logic          last_try;
  logic [7:0]    fb_val;

  // Smallest 2^k-1 >= l-1. Limit 0 wraps to 0xFF, limit 1 yields 0.
  function automatic logic [7:0] mask_for(input logic [7:0] l);
    logic [7:0] m;
    m = l - 8'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  // Out-of-range candidates fold back by one limit; since mask < 2*lim the
  // result is in range. A candidate that is already in range (only possible
  // when it was rejected as a repeat) is returned unchanged.
  function automatic logic [7:0] fold(input logic [7:0] c, input logic [8:0] le);
    logic [8:0] c9;
    c9 = {1'b0, c};
    if (c9 >= le) return 8'(c9 - le);
    return c;
  endfunction

`ifdef RAND_RANGE_NO_REPEAT_EN
  logic [7:0] prev, prev_next;

  // Step a fallback that matches the previous result to the next value,
  // wrapping at the limit.
  function automatic logic [7:0] avoid_repeat(input logic [7:0] r,
                                              input logic [7:0] p,
                                              input logic [8:0] le);
    if (le < 9'd2 || r != p) return r;
    if ({1'b0, r} + 9'd1 == le) return 8'd0;
    return r + 8'd1;
  endfunction
`endif

  assign lim_ext   = (lim == 8'd0) ? 9'd256 : {1'b0, lim};
  assign cand      = rnd_in & mask;
  assign tries_inc = tries + 1'b1;
  assign last_try  = (tries_inc == TW'(MAX_TRIES));
  assign busy      = (state == DRAW);

`ifdef RAND_RANGE_NO_REPEAT_EN
  assign reject = ({1'b0, cand} >= lim_ext) ||
                  ((lim_ext >= 9'd2) && (cand == prev));
  assign fb_val = avoid_repeat(fold(cand, lim_ext), prev, lim_ext);
`else
  assign reject = ({1'b0, cand} >= lim_ext);
  assign fb_val = fold(cand, lim_ext);
`endif

  always_comb begin
    state_next = state;
    lim_next   = lim;
    mask_next  = mask;
    tries_next = tries;
    value_next = value;
    valid_next = 1'b0;
`ifdef RAND_RANGE_NO_REPEAT_EN
    prev_next  = prev;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          lim_next   = limit;
          mask_next  = mask_for(limit);
          tries_next = '0;
          state_next = DRAW;
        end
      end
      DRAW: begin
        tries_next = tries_inc;
        if (!reject) begin
          value_next = cand;
          valid_next = 1'b1;
          state_next = IDLE;
`ifdef RAND_RANGE_NO_REPEAT_EN
          prev_next  = cand;
`endif
        end else if (last_try) begin
          value_next = fb_val;
          valid_next = 1'b1;
          state_next = IDLE;
`ifdef RAND_RANGE_NO_REPEAT_EN
          prev_next  = fb_val;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched limit and mask are data only; they are rewritten on every request.
  always_ff @(posedge clk) begin
    lim  <= lim_next;
    mask <= mask_next;
    if (reset) begin
      state <= IDLE;
      value <= 8'd0;
      valid <= 1'b0;
      tries <= '0;
`ifdef RAND_RANGE_NO_REPEAT_EN
      prev  <= 8'd0;
`endif
    end else begin
      state <= state_next;
      value <= value_next;
      valid <= valid_next;
      tries <= tries_next;
`ifdef RAND_RANGE_NO_REPEAT_EN
      prev  <= prev_next;
`endif
    end
  end

endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range: scoreboard bench for rand_range. Each request pushes the
// expected value and the clock edge after which valid must appear; a negedge
// monitor pops and compares whenever valid is seen.
module tb_rand_range;

  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rnd_in;
  logic       req;
  logic [7:0] limit;
  logic [7:0] value;
  logic       valid;
  logic       busy;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t head;

  rand_range #(.MAX_TRIES(MT)) dut (
    .clk    (clk),
    .reset  (reset),
    .rnd_in (rnd_in),
    .req    (req),
    .limit  (limit),
    .value  (value),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Called at a negedge: raises req for one edge, then presents rnd_v.
  // Returns k, the edge that samples the request.
  task automatic issue(input logic [7:0] lim_v, input logic [7:0] rnd_v,
                       output int k);
    req   = 1'b1;
    limit = lim_v;
    k     = cyc + 1;
    @(negedge clk);
    req    = 1'b0;
    rnd_in = rnd_v;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          head = sb.pop_front();
          check("value", int'(value), int'(head.val));
          check("latency", cyc, head.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check("missing_valid", 0, 1);
        head = sb.pop_front();
      end
    end
  end

  initial begin
    int k;
    reset  = 1'b1;
    req    = 1'b0;
    limit  = 8'd0;
    rnd_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_value", int'(value), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Reject 11, accept 7 on the second evaluation.
    issue(8'd10, 8'h2B, k);
    push(8'd7, k + 2);
    check("busy_draw1", int'(busy), 1);
    @(negedge clk);
    rnd_in = 8'h37;
    check("busy_draw2", int'(busy), 1);
    @(negedge clk);
    check("busy_done", int'(busy), 0);

    // All tries reject 15; fallback 15-10.
    issue(8'd10, 8'h0F, k);
    push(8'd5, k + MT);
    repeat (MT) @(negedge clk);
    check("busy_after_fb", int'(busy), 0);

    // limit 0 means 256; limit 1 always yields 0.
    issue(8'd0, 8'hA5, k);
    push(8'hA5, k + 1);
    @(negedge clk);
    issue(8'd1, 8'hFF, k);
    push(8'd0, k + 1);
    @(negedge clk);

    // Request raised in the valid cycle is taken immediately.
    issue(8'd4, 8'h02, k);
    push(8'd2, k + 1);
    @(negedge clk);
    issue(8'd4, 8'h02, k);
`ifdef RAND_RANGE_NO_REPEAT_EN
    push(8'd3, k + MT);
`else
    push(8'd2, k + 1);
`endif
    repeat (MT) @(negedge clk);

    // req during DRAW is ignored, limit change too.
    issue(8'd10, 8'h0F, k);
    @(negedge clk);
    req   = 1'b1;
    limit = 8'd3;
    @(negedge clk);
    req    = 1'b0;
    limit  = 8'd10;
    rnd_in = 8'h06;
    push(8'd6, k + 3);
    repeat (4) @(negedge clk);

    // Reset on the second DRAW cycle drops the request.
    issue(8'd10, 8'h0F, k);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_value", int'(value), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_busy", int'(busy), 0);
    issue(8'd10, 8'h04, k);
    push(8'd4, k + 1);
    repeat (2) @(negedge clk);

`ifdef RAND_RANGE_NO_REPEAT_EN
    issue(8'd10, 8'h07, k);
    push(8'd7, k + 1);
    @(negedge clk);
    issue(8'd10, 8'h07, k);
    push(8'd3, k + 2);
    @(negedge clk);
    rnd_in = 8'h03;
    @(negedge clk);
    issue(8'd10, 8'h03, k);
    push(8'd4, k + MT);
    repeat (MT) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
